// File: rtl/dff_share_pkg.sv
// Shared types and default sizing for the DFF share arbiter slice.
package dff_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               any,
  output logic [SRC_W-1:0]   winner
);

  // Two passes over absolute indices: [ptr, NUM_REQ) first, then the wrapped [0, ptr).
  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (SRC_W'(j) >= ptr)) begin
        any    = 1'b1;
        winner = SRC_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (SRC_W'(j) < ptr)) begin
        any    = 1'b1;
        winner = SRC_W'(j);
      end
    end
  end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that captures one requester's word into a shared register
// and holds it for downstream with a valid/ack handshake.
module dff_share_arbiter
  import dff_share_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int DATA_W  = DEF_DATA_W,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  output logic [SRC_W-1:0]          dout_src,
  input  logic                      dout_ack,
  output logic                      busy
);

  localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

  state_e              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [SRC_W-1:0]    sel_q;
  logic [SRC_W-1:0]    ptr_q;
  logic [SRC_W-1:0]    ptr_d;
  logic [DATA_W-1:0]   dout_q;
  logic [DATA_W-1:0]   cap_d;
  logic [SRC_W-1:0]    src_q;
  logic                valid_q;
  logic                pick_any;
  logic [SRC_W-1:0]    pick_win;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .winner (pick_win)
  );

  always_comb begin
    cap_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel_q == SRC_W'(i)) begin
        cap_d = din[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_d = (sel_q == SRC_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      dout_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_q   <= GNT_ONE << pick_win;
            sel_q   <= pick_win;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          // Capture regardless of req[sel]; the requester keeps din stable while granted.
          dout_q  <= cap_d;
          src_q   <= sel_q;
          valid_q <= 1'b1;
          gnt_q   <= '0;
          ptr_q   <= ptr_d;
          state_q <= HOLD;
        end
        HOLD: begin
          if (dout_ack) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          gnt_q   <= '0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_src   = src_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed self-checking bench for dff_share_arbiter (4 requesters, 8-bit data).
module tb_dff_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [7:0]  dout;
  logic        dout_valid;
  logic [1:0]  dout_src;
  logic        dout_ack;
  logic        busy;

  int unsigned n_checks;
  int unsigned n_errors;

  dff_share_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_src   (dout_src),
    .dout_ack   (dout_ack),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    req      = 4'b0000;
    din      = 32'h0;
    dout_ack = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt",   32'(gnt),        32'h0);
    chk("rst_dout",  32'(dout),       32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_src",   32'(dout_src),   32'h0);
    chk("rst_busy",  32'(busy),       32'h0);
    rst = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // Round robin with all requests held
    req = 4'b1111;
    din = 32'h13121110;
    for (int unsigned k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt",   32'(gnt),        32'(4'b0001 << (k % 4)));
      chk("rr_busy",  32'(busy),       32'h1);
      tick();
      chk("rr_dout",  32'(dout),       32'h10 + 32'(k % 4));
      chk("rr_src",   32'(dout_src),   32'(k % 4));
      chk("rr_valid", 32'(dout_valid), 32'h1);
      chk("rr_gnt0",  32'(gnt),        32'h0);
      dout_ack = 1'b1;
      tick();
      dout_ack = 1'b0;
      chk("rr_ackv",  32'(dout_valid), 32'h0);
    end
    req = 4'b0000;

    // Single request from requester 2 (pointer currently 1)
    din = 32'h003C0000;
    req = 4'b0100;
    tick();
    chk("s_gnt",   32'(gnt),        32'h4);
    chk("s_valid", 32'(dout_valid), 32'h0);
    req = 4'b0000;
    tick();
    chk("s_gnt0",  32'(gnt),        32'h0);
    chk("s_dout",  32'(dout),       32'h3C);
    chk("s_src",   32'(dout_src),   32'h2);
    chk("s_valid1", 32'(dout_valid), 32'h1);
    dout_ack = 1'b1;
    tick();
    dout_ack = 1'b0;
    chk("s_ackv",  32'(dout_valid), 32'h0);
    chk("s_ackb",  32'(busy),       32'h0);
    chk("s_keep",  32'(dout),       32'h3C);

    // Wrap-around: grant 3, then 0011 must go to 0
    din = 32'h55002211;
    req = 4'b1000;
    tick();
    chk("w_gnt3",  32'(gnt),      32'h8);
    req = 4'b0000;
    tick();
    chk("w_dout3", 32'(dout),     32'h55);
    chk("w_src3",  32'(dout_src), 32'h3);
    dout_ack = 1'b1;
    tick();
    dout_ack = 1'b0;
    req = 4'b0011;
    tick();
    chk("w_gnt0",  32'(gnt),      32'h1);
    req = 4'b0010;
    tick();
    chk("w_dout0", 32'(dout),     32'h11);
    chk("w_src0",  32'(dout_src), 32'h0);

    // Backpressure: 10 cycles in HOLD with req1 pending
    for (int unsigned k = 0; k < 10; k++) begin
      tick();
      chk("bp_gnt",  32'(gnt),        32'h0);
      chk("bp_dout", 32'(dout),       32'h11);
      chk("bp_busy", 32'(busy),       32'h1);
      chk("bp_vld",  32'(dout_valid), 32'h1);
    end
    dout_ack = 1'b1;
    tick();
    dout_ack = 1'b0;
    chk("bp_ackg", 32'(gnt),        32'h0);
    chk("bp_ackv", 32'(dout_valid), 32'h0);
    chk("bp_ackb", 32'(busy),       32'h0);
    tick();
    chk("bp_gnt1", 32'(gnt),        32'h2);
    req = 4'b0000;
    tick();
    chk("bp_dout1", 32'(dout),      32'h22);
    chk("bp_src1",  32'(dout_src),  32'h1);
    dout_ack = 1'b1;
    tick();

    // Stray ack in IDLE has no effect
    tick();
    tick();
    dout_ack = 1'b0;
    chk("sa_valid", 32'(dout_valid), 32'h0);
    chk("sa_busy",  32'(busy),       32'h0);
    chk("sa_gnt",   32'(gnt),        32'h0);
    chk("sa_dout",  32'(dout),       32'h22);

    // Request 0 dropped during GRANT is still captured
    din = 32'h00000077;
    req = 4'b0001;
    tick();
    chk("dr_gnt",   32'(gnt),        32'h1);
    req = 4'b0000;
    tick();
    chk("dr_dout",  32'(dout),       32'h77);
    chk("dr_src",   32'(dout_src),   32'h0);
    chk("dr_valid", 32'(dout_valid), 32'h1);
    dout_ack = 1'b1;
    tick();
    dout_ack = 1'b0;

    // Asynchronous reset in HOLD with dout = A5
    din = 32'h0000A500;
    req = 4'b0010;
    tick();
    chk("ar_gnt",  32'(gnt),  32'h2);
    req = 4'b0000;
    tick();
    chk("ar_dout", 32'(dout), 32'hA5);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_gnt0",   32'(gnt),        32'h0);
    chk("ar_dout0",  32'(dout),       32'h0);
    chk("ar_valid0", 32'(dout_valid), 32'h0);
    chk("ar_src0",   32'(dout_src),   32'h0);
    chk("ar_busy0",  32'(busy),       32'h0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("post_busy",  32'(busy),       32'h0);
    chk("post_gnt",   32'(gnt),        32'h0);
    chk("post_valid", 32'(dout_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
